// File: rtl/adder_pipe_stage_if.sv
// rtl/adder_pipe_stage_if.sv - operand/result handshake bundle for the adder pipe stage
interface adder_pipe_stage_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         in_acc;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_acc, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_acc, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - two-stage add/accumulate pipeline with valid/ready flow control
module adder_pipe_stage #(
    parameter int N = 32
) (
    input logic              clk,
    input logic              rst,
    adder_pipe_stage_if.slave bus
);

    // S1: registered operand set
    logic         s1_valid;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    logic         s1_cin;
    logic         s1_acc;

    // S2: registered result; s2_sum doubles as the accumulator
    logic         s2_valid;
    logic [N-1:0] s2_sum;
    logic         s2_cout;
    logic         s2_ovf;
    logic         s2_zero;

    logic         advance;
    logic         accept;
    logic [N-1:0] op_a;
    logic [N:0]   full_sum;

    // Flow control and the adder itself; the accumulator read is the result
    // currently in S2, which is always the previous set in program order.
    always_comb begin
        advance  = s1_valid && (!s2_valid || bus.out_ready);
        accept   = bus.in_valid && (!s1_valid || advance);
        op_a     = s1_acc ? s2_sum : s1_a;
        full_sum = {1'b0, op_a} + {1'b0, s1_b} + {{N{1'b0}}, s1_cin};
    end

    assign bus.in_ready  = !s1_valid || advance;
    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = s2_sum;
    assign bus.out_cout  = s2_cout;
    assign bus.out_ovf   = s2_ovf;
    assign bus.out_zero  = s2_zero;

    // S1 captures a new operand set on handshake, empties when it advances alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_acc   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_cin   <= bus.in_cin;
            s1_acc   <= bus.in_acc;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 loads the sum and flags on advance, holds under backpressure, and keeps
    // the last sum after consumption so it can serve as the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_cout  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_zero  <= 1'b1;
        end else if (advance) begin
            s2_valid <= 1'b1;
            s2_sum   <= full_sum[N-1:0];
            s2_cout  <= full_sum[N];
            s2_ovf   <= (op_a[N-1] == s1_b[N-1]) && (full_sum[N-1] != op_a[N-1]);
            s2_zero  <= (full_sum[N-1:0] == '0);
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_pipe_stage.sv
// tb/tb_adder_pipe_stage.sv - scoreboard bench for adder_pipe_stage
module tb_adder_pipe_stage;

    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adder_pipe_stage_if #(.N(N)) bus ();

    adder_pipe_stage #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    logic [N-1:0] model_acc = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c, input logic acc);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = c;
        bus.in_acc   = acc;
    endtask

    // Present a set at the current falling edge and return at the falling edge
    // after the rising edge that accepted it.
    task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c, input logic acc);
        bit ok;
        ok = 1'b0;
        drive(1'b1, a, b, c, acc);
        for (int i = 0; i < 50 && !ok; i++) begin
            #4;
            ok = bus.in_ready;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL offer_timeout: in_ready stayed 0 for 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    // Monitor and reference model: samples just before each rising edge.
    initial begin
        res_t         e;
        res_t         held;
        bit           stall;
        logic [N-1:0] a_sel;
        logic [N:0]   t;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                model_acc = '0;
                stall     = 1'b0;
            end else begin
                if (stall)
                    check("stall_hold", {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero}, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_result: got sum %0h with nothing expected", bus.out_sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum",  bus.out_sum,  e.sum);
                        check("cout", bus.out_cout, e.cout);
                        check("ovf",  bus.out_ovf,  e.ovf);
                        check("zero", bus.out_zero, e.zero);
                    end
                end
                stall = bus.out_valid && !bus.out_ready;
                held  = {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_zero};
                if (bus.in_valid && bus.in_ready) begin
                    a_sel  = bus.in_acc ? model_acc : bus.in_a;
                    t      = {1'b0, a_sel} + {1'b0, bus.in_b} + (N+1)'(bus.in_cin);
                    e.sum  = t[N-1:0];
                    e.cout = t[N];
                    e.ovf  = (a_sel[N-1] == bus.in_b[N-1]) && (t[N-1] != a_sel[N-1]);
                    e.zero = (t[N-1:0] == 0);
                    model_acc = t[N-1:0];
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_sum",       bus.out_sum,   0);
        check("rst_cout",      bus.out_cout,  0);
        check("rst_ovf",       bus.out_ovf,   0);
        check("rst_zero",      bus.out_zero,  1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // basic add and latency
        offer(32'd1349, 32'd4755, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        check("lat_first_cycle", bus.out_valid, 0);
        @(negedge clk);
        #1;
        check("lat_second_cycle", bus.out_valid, 1);
        check("lat_sum", bus.out_sum, 6104);
        @(negedge clk);
        idle(2);

        // carry / zero / overflow boundaries
        offer(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        offer(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        idle(4);

        // back-to-back accumulate
        offer(32'd10, 32'd0, 1'b0, 1'b0);
        offer(32'hDEAD_BEEF, 32'd5, 1'b1, 1'b1);
        offer(32'h1234_5678, 32'hFFFF_FFF0, 1'b0, 1'b1);
        idle(4);

        // backpressure: two accepted, third held off
        bus.out_ready = 1'b0;
        offer(32'd1, 32'd0, 1'b0, 1'b0);
        offer(32'd2, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd3, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready",  bus.in_ready,  0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_sum",   bus.out_sum,   1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        offer(32'd3, 32'd0, 1'b0, 1'b0);
        idle(5);

        // reset in flight, accumulator restarts from 0
        offer(32'd3, 32'd0, 1'b0, 1'b0);
        offer(32'd4, 32'd0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        offer(32'hABCD_0000, 32'd7, 1'b0, 1'b1);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: ra = 32'h7FFF_FFFF;
                2: rb = 32'h8000_0000;
                3: rb = -ra;
                default: ;
            endcase
            drive(($urandom_range(0, 9) < 7), ra, rb, 1'($urandom), ($urandom_range(0, 9) < 3));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end

        // drain
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
